// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM duty widths, period length, duty type and ramp state enum
package pwm_pkg;
    localparam int DUTY_W = 11;
    localparam int PERIOD = 2048;
    typedef logic [DUTY_W-1:0] duty_t;
    typedef enum logic {IDLE, RAMP} ramp_state_t;
endpackage

// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: target-duty valid/ready channel (tgt_duty, tgt_vld in; tgt_rdy out of the slave)
interface pwm_duty_ramp_if;
    import pwm_pkg::*;
    duty_t tgt_duty;
    logic  tgt_vld;
    logic  tgt_rdy;
    modport master (output tgt_duty, output tgt_vld, input tgt_rdy);
    modport slave (input tgt_duty, input tgt_vld, output tgt_rdy);
endinterface

// File: rtl/pwm_period_tick.sv
// pwm_period_tick: mirrors the PWM period counter and divides boundaries into ramp steps; in clk, rst, clr; out period_end, step_due
module pwm_period_tick
    import pwm_pkg::*;
#(
    parameter int RAMP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic period_end,
    output logic step_due
);
    duty_t      pcnt;
    logic [7:0] dcnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            dcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            dcnt <= (clr || step_due) ? '0 : period_end ? dcnt + 1'b1 : dcnt;
        end
    end
    assign period_end = pcnt == duty_t'(PERIOD - 1);
    assign step_due   = period_end && dcnt == 8'(RAMP_DIV - 1);
endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: soft-start duty ramp toward an accepted target at period boundaries; in clk, rst, tgt (slave), kill; out duty, ramping, done, period_end
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int STEP     = 16,
    parameter int RAMP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    pwm_duty_ramp_if.slave   tgt,
    input  logic             kill,
    output duty_t            duty,
    output logic             ramping,
    output logic             done,
    output logic             period_end
);
    localparam logic [11:0] STEP_12 = 12'(STEP);
    ramp_state_t state, state_nxt;
    duty_t       target, step_duty;
    logic        accept, step_due, up, hit;
    logic [11:0] gap;
    pwm_period_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .clr        (kill || accept),
        .period_end (period_end),
        .step_due   (step_due)
    );
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end
    // 12-bit gap keeps the compare against STEP free of wrap; the add/sub only runs when gap > STEP
    always_comb begin
        up        = target > duty;
        gap       = up ? {1'b0, target} - {1'b0, duty} : {1'b0, duty} - {1'b0, target};
        step_duty = gap <= STEP_12 ? target : up ? duty + STEP_12[10:0] : duty - STEP_12[10:0];
        hit       = step_due && step_duty == target;
        state_nxt = kill ? IDLE :
                    state == IDLE ? ((accept && tgt.tgt_duty != duty) ? RAMP : IDLE) :
                    (hit ? IDLE : RAMP);
    end
    always_comb begin
        tgt.tgt_rdy = state == IDLE && !kill;
        accept      = state == IDLE && !kill && tgt.tgt_vld;
        ramping     = state == RAMP;
    end
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            duty   <= '0;
            target <= '0;
            done   <= 1'b0;
        end else begin
            done <= accept ? tgt.tgt_duty == duty : state == RAMP && hit;
            if (accept) target <= tgt.tgt_duty;
            if (state == RAMP && step_due) duty <= step_duty;
        end
    end
endmodule
